sra_iter: RTL and testbench

SRA_ITER -- requirements
Module: sra_iter

---
 rtl/sra_iter_pkg.sv | 6 +
 rtl/sra_iter_step.sv | 11 +
 rtl/sra_iter.sv | 64 ++++++
 tb/tb_sra_iter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sra_iter_pkg.sv
// sra_iter_pkg: shared datapath widths and FSM state encoding for the iterative shifter.
package sra_iter_pkg;
   localparam int XLEN = 32;
   localparam int SHW  = 5;
   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_e;
endpackage

// File: rtl/sra_iter_step.sv
// sra_step: one combinational right-shift stage; vacated bits take the fill value.
module sra_step
   import sra_iter_pkg::*;
(
   input  logic [XLEN-1:0] data,
   input  logic [SHW-1:0]  k,
   input  logic            fill,
   output logic [XLEN-1:0] res
);
   assign res = (data >> k) | (fill ? ~({XLEN{1'b1}} >> k) : '0);
endmodule

// File: rtl/sra_iter.sv
// sra_iter: iterative SRA/SRL unit, shifts STEP bits per cycle and pulses done with the result.
module sra_iter
   import sra_iter_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [SHW-1:0]  shamt,
   input  logic            arith,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] out
);
   state_e          state_q;
   logic [XLEN-1:0] work_q, work_d, out_q;
   logic [SHW-1:0]  cnt_q, cnt_d, n, k;
   logic            fill_q, busy_q, done_q, accept, unused_b;
   assign unused_b = ^b[XLEN-1:SHW];
   assign n        = shamt != '0 ? shamt : b[SHW-1:0];
   assign accept   = start && state_q != SHIFT;
   // the final step is partial when fewer than STEP bits remain
   assign k        = cnt_q < SHW'(STEP) ? cnt_q : SHW'(STEP);
   assign cnt_d    = cnt_q - k;
   sra_step u_step (.data(work_q), .k(k), .fill(fill_q), .res(work_d));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (accept) begin
         work_q  <= a;
         cnt_q   <= n;
         fill_q  <= arith & a[XLEN-1];
         state_q <= n == '0 ? FIN : SHIFT;
         busy_q  <= n != '0;
         done_q  <= n == '0;
         if (n == '0) out_q <= a;
      end else if (state_q == SHIFT) begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         if (cnt_d == '0) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= work_d;
         end
      end else begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;
endmodule

// File: tb/tb_sra_iter.sv
// tb_sra_iter: runs one sra_iter per legal STEP in parallel against a shift-arithmetic reference.
module tb_sra_iter;
   typedef struct {
      int          step;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        ar;
      logic [31:0] eo;
      int          lat;
   } vec_t;
   logic clk;
   int   checks, errors;
   vec_t tbl[10];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction
   function automatic logic [31:0] model(logic [31:0] av, logic [4:0] nv, logic ar);
      logic signed [31:0] s;
      s = $signed(av) >>> nv;
      return ar ? 32'(s) : av >> nv;
   endfunction
   function automatic int lat(int nv, int s);
      return (nv + s - 1) / s + 1;
   endfunction
   for (genvar g = 0; g < 4; g++) begin : ln
      localparam int S = 1 << g;
      logic        rst_n, start, arith, busy, done;
      logic [31:0] a, b, out;
      logic [4:0]  shamt;
      bit          fin;
      sra_iter #(.STEP(S)) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .shamt(shamt),
         .arith(arith), .busy(busy), .done(done), .out(out)
      );
      task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic [4:0] si,
                            input logic ar, input logic [31:0] eo, input int el, input string nm);
         int c;
         a = ai; b = bi; shamt = si; arith = ar; start = 1'b1;
         @(negedge clk);
         start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
         c = 1;
         while (!done && c < 40) begin
            @(negedge clk);
            c++;
         end
         chk({nm, " latency"}, 32'(c), 32'(el));
         chk({nm, " out"}, out, eo);
         chk({nm, " busy at done"}, 32'(busy), 32'd0);
      endtask
      initial begin
         int          pulses, l1, l2;
         logic [31:0] ra, rb;
         logic [4:0]  rs, rn;
         logic        rr;
         string       p;
         p = $sformatf("S%0d", S);
         rst_n = 1'b0; start = 1'b1; a = '1; b = '1; shamt = '1; arith = 1'b1;
         repeat (3) @(negedge clk);
         chk({p, " reset busy"}, 32'(busy), 32'd0);
         chk({p, " reset done"}, 32'(done), 32'd0);
         chk({p, " reset out"}, out, 32'd0);
         rst_n = 1'b1;
         run_op(32'h8000_0000, 32'd0, 5'd2, 1'b1, 32'hE000_0000, lat(2, S), {p, " first accept"});
         foreach (tbl[i]) if (tbl[i].step == S) begin
            @(negedge clk);
            run_op(tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].ar, tbl[i].eo, tbl[i].lat,
                   $sformatf("%s vec%0d", p, i));
         end
         @(negedge clk);
         a = 32'h8000_0000; b = 32'd0; shamt = 5'd31; arith = 1'b1; start = 1'b1;
         pulses = 0;
         for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) chk({p, " busy in shift"}, 32'(busy), 32'd1);
            if (done) begin
               pulses++;
               if (pulses == 1) begin
                  chk({p, " ignored-start latency"}, 32'(c), 32'(lat(31, S)));
                  chk({p, " ignored-start out"}, out, 32'hFFFF_FFFF);
               end
            end
            start = c == 2;
            if (c == 2) begin a = 32'h0000_1234; shamt = 5'd1; arith = 1'b0; end
         end
         chk({p, " ignored-start pulses"}, 32'(pulses), 32'd1);
         @(negedge clk);
         l1 = lat(3, S);
         l2 = lat(4, S);
         a = 32'h8000_0000; shamt = 5'd3; arith = 1'b1; start = 1'b1;
         pulses = 0;
         for (int c = 1; c <= l1 + l2 + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin a = 32'h0000_0F00; shamt = 5'd4; arith = 1'b0; end
            if (c == l1 + 1) start = 1'b0;
            if (done) begin
               pulses++;
               if (pulses == 1) begin
                  chk({p, " b2b first latency"}, 32'(c), 32'(l1));
                  chk({p, " b2b first out"}, out, 32'hF000_0000);
                  chk({p, " b2b busy in fin"}, 32'(busy), 32'd0);
               end else if (pulses == 2) begin
                  chk({p, " b2b second latency"}, 32'(c), 32'(l1 + l2));
                  chk({p, " b2b second out"}, out, 32'h0000_00F0);
               end
            end
         end
         chk({p, " b2b pulses"}, 32'(pulses), 32'd2);
         @(negedge clk);
         a = 32'hFFFF_FFFF; shamt = 5'd20; arith = 1'b1; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         chk({p, " busy before abort"}, 32'(busy), 32'd1);
         rst_n = 1'b0;
         #1;
         chk({p, " abort busy"}, 32'(busy), 32'd0);
         chk({p, " abort done"}, 32'(done), 32'd0);
         chk({p, " abort out"}, out, 32'd0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         pulses = 0;
         repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
         end
         chk({p, " abort pulses"}, 32'(pulses), 32'd0);
         chk({p, " abort out after"}, out, 32'd0);
         for (int i = 0; i < 2500; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = $urandom_range(1) != 0 ? 5'($urandom) : 5'd0;
            rr = 1'($urandom);
            rn = rs != 5'd0 ? rs : rb[4:0];
            if ($urandom_range(1) == 1) @(negedge clk);
            run_op(ra, rb, rs, rr, model(ra, rn, rr), lat(int'(rn), S), {p, " random"});
         end
         fin = 1'b1;
      end
   end
   initial begin
      tbl[0] = '{1, 32'h8000_0000, 32'd0,         5'd4,  1'b1, 32'hF800_0000, 5};
      tbl[1] = '{1, 32'h8000_0000, 32'd31,        5'd0,  1'b0, 32'h0000_0001, 32};
      tbl[2] = '{4, 32'h1234_5678, 32'd0,         5'd0,  1'b0, 32'h1234_5678, 1};
      tbl[3] = '{4, 32'hFFFF_0000, 32'd0,         5'd7,  1'b1, 32'hFFFF_FE00, 3};
      tbl[4] = '{2, 32'h8000_0000, 32'd0,         5'd31, 1'b1, 32'hFFFF_FFFF, 17};
      tbl[5] = '{8, 32'h7FFF_FFFF, 32'hFFFF_FFE9, 5'd0,  1'b1, 32'h003F_FFFF, 3};
      tbl[6] = '{8, 32'hF000_0000, 32'd0,         5'd8,  1'b0, 32'h00F0_0000, 2};
      tbl[7] = '{2, 32'h0000_0001, 32'd0,         5'd1,  1'b1, 32'h0000_0000, 2};
      tbl[8] = '{1, 32'hC000_0000, 32'd0,         5'd0,  1'b1, 32'hC000_0000, 1};
      tbl[9] = '{4, 32'h0000_FF00, 32'd8,         5'd4,  1'b0, 32'h0000_0FF0, 2};
      fork
         wait (ln[0].fin && ln[1].fin && ln[2].fin && ln[3].fin);
         #2000000;
      join_any
      if (!(ln[0].fin && ln[1].fin && ln[2].fin && ln[3].fin)) begin
         errors++;
         $display("FAIL timeout: lanes finished %b%b%b%b required 1111",
                  ln[3].fin, ln[2].fin, ln[1].fin, ln[0].fin);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
